clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen.sv | 153 +++++++++++++++
 tb/tb_clk_div_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with lock FSM and glitch-free ratio updates.
// Define CLK_DIV_GEN_LOCK_EN to insert a LOCK_CYC-cycle acquisition phase before lock.
module clk_div_gen #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 4,
  parameter int LOCK_CYC = 20
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    BYPASS,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic                    DIV_VLD,
  output logic                    DIV_ACK,
  output logic                    LOCK,
  output logic [NUM_CH-1:0]       OUTCLK
);

  localparam int ACQ_W = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);

  typedef enum logic [1:0] {
    RESET_IDLE,
    ACQ,
    LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [ACQ_W-1:0]       acq_cnt_q, acq_cnt_d;
  logic                   lock_q, lock_d;
  logic                   ack_q, ack_d;
  logic                   pending_q, pending_d;
  logic [NUM_CH-1:0]      applied_q, applied_d;
  logic [NUM_CH-1:0]      out_q, out_d;
  logic [DIV_W-1:0]       act_q    [NUM_CH];
  logic [DIV_W-1:0]       act_d    [NUM_CH];
  logic [DIV_W-1:0]       cnt_q    [NUM_CH];
  logic [DIV_W-1:0]       cnt_d    [NUM_CH];
  logic [DIV_W-1:0]       shadow_q [NUM_CH];
  logic [DIV_W-1:0]       shadow_d [NUM_CH];
  logic                   load_act;
  logic                   run_ch;

  always_comb begin
    state_d   = state_q;
    acq_cnt_d = acq_cnt_q;
    lock_d    = lock_q;
    ack_d     = 1'b0;
    pending_d = pending_q;
    applied_d = applied_q;
    out_d     = out_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    load_act  = 1'b0;
    run_ch    = 1'b0;

    unique case (state_q)
      RESET_IDLE: begin
`ifdef CLK_DIV_GEN_LOCK_EN
        state_d   = ACQ;
        acq_cnt_d = '0;
`else
        state_d   = LOCKED;
        lock_d    = 1'b1;
        load_act  = 1'b1;
`endif
      end
      ACQ: begin
        if (acq_cnt_q == ACQ_W'(LOCK_CYC - 1)) begin
          state_d  = LOCKED;
          lock_d   = 1'b1;
          load_act = 1'b1;
        end else begin
          acq_cnt_d = acq_cnt_q + ACQ_W'(1);
        end
      end
      LOCKED:  run_ch  = 1'b1;
      default: state_d = RESET_IDLE;
    endcase

    if (load_act) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_d[i] = DIV[i*DIV_W +: DIV_W];
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end
    end

    if (run_ch) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (act_q[i] == '0) begin
          cnt_d[i] = '0;
          out_d[i] = 1'b0;
        end else if (cnt_q[i] == act_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          out_d[i] = ~out_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        // Swap ratio only on a falling toggle (or when idle) so the new low phase starts clean.
        if (pending_q && !applied_q[i] &&
            ((act_q[i] == '0) || (out_q[i] && (cnt_q[i] == act_q[i] - DIV_W'(1))))) begin
          act_d[i]     = shadow_q[i];
          cnt_d[i]     = '0;
          out_d[i]     = 1'b0;
          applied_d[i] = 1'b1;
        end
      end

      if (pending_q && (&applied_d)) begin
        ack_d     = 1'b1;
        pending_d = 1'b0;
        applied_d = '0;
      end else if (!pending_q && DIV_VLD) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          shadow_d[i] = DIV[i*DIV_W +: DIV_W];
        end
        pending_d = 1'b1;
        applied_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= RESET_IDLE;
      acq_cnt_q <= '0;
      lock_q    <= 1'b0;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      applied_q <= '0;
      out_q     <= '0;
      act_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
    end else begin
      state_q   <= state_d;
      acq_cnt_q <= acq_cnt_d;
      lock_q    <= lock_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      applied_q <= applied_d;
      out_q     <= out_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign OUTCLK  = BYPASS ? {NUM_CH{CLK}} : out_q;
  assign DIV_ACK = ack_q;
  assign LOCK    = lock_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: expected per-cycle samples are queued with the
// stimulus and popped by monitors on the low phase and just after the rising edge.
module tb_clk_div_gen;

  localparam int NUM_CH   = 4;
  localparam int DIV_W    = 4;
  localparam int LOCK_CYC = 20;
`ifdef CLK_DIV_GEN_LOCK_EN
  localparam int LAT = LOCK_CYC + 1;
`else
  localparam int LAT = 1;
`endif

  logic                    CLK;
  logic                    RST_N;
  logic                    BYPASS;
  logic [NUM_CH*DIV_W-1:0] DIV;
  logic                    DIV_VLD;
  logic                    DIV_ACK;
  logic                    LOCK;
  logic [NUM_CH-1:0]       OUTCLK;

  clk_div_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .BYPASS (BYPASS),
    .DIV    (DIV),
    .DIV_VLD(DIV_VLD),
    .DIV_ACK(DIV_ACK),
    .LOCK   (LOCK),
    .OUTCLK (OUTCLK)
  );

  typedef struct {
    int         cyc;
    logic       lock;
    logic       ack;
    logic [3:0] clk;
    string      tag;
  } exp_t;

  exp_t qlo[$];
  exp_t qhi[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic wave(input int k, input int d);
    if (d == 0 || k < 0) return 1'b0;
    return ((k / d) % 2) == 1;
  endfunction

  function automatic exp_t mk(input int c, input logic l, input logic a,
                              input logic [3:0] o, input string t);
    exp_t e;
    e.cyc = c; e.lock = l; e.ack = a; e.clk = o; e.tag = t;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if ({LOCK, DIV_ACK, OUTCLK} !== {e.lock, e.ack, e.clk}) begin
      errors++;
      $display("FAIL %s cyc=%0d got lock=%b ack=%b outclk=%b expected lock=%b ack=%b outclk=%b",
               e.tag, e.cyc, LOCK, DIV_ACK, OUTCLK, e.lock, e.ack, e.clk);
    end
  endtask

  task automatic drop_stale(inout exp_t q[$]);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d sample missed at cyc=%0d", q[0].tag, q[0].cyc, cyc);
      void'(q.pop_front());
    end
  endtask

  always @(negedge CLK) begin
    drop_stale(qlo);
    if (qlo.size() > 0 && qlo[0].cyc == cyc) compare(qlo.pop_front());
  end

  always @(posedge CLK) begin
    #2;
    drop_stale(qhi);
    if (qhi.size() > 0 && qhi[0].cyc == cyc) compare(qhi.pop_front());
  end

  task automatic after_edge(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int R, L, R2, L2, k;
    logic [3:0] o;
    RST_N   = 1'b0;
    BYPASS  = 1'b0;
    DIV_VLD = 1'b0;
    DIV     = 16'h3210;
    for (int c = 1; c <= 2; c++) qlo.push_back(mk(c, 1'b0, 1'b0, 4'h0, "reset_state"));

    // Lock sequence with ratios {3,2,1,0}; ch1 moves 1->5 at its 1->0 edge L+14.
    R = 2;
    L = R + LAT;
    after_edge(R);
    for (int c = R + 1; c <= L + 50; c++) begin
      k = c - L;
      if (c >= L + 30 && c <= L + 35) o = 4'h0;
      else o = {wave(k, 3), wave(k, 2), (c < L + 14) ? wave(k, 1) : wave(c - L - 14, 5), 1'b0};
      qlo.push_back(mk(c, c >= L, c == L + 18,
                       o, (c < L) ? "lock_seq" : (c < L + 30) ? "divide_update" : "bypass_resume"));
    end
    for (int c = L + 31; c <= L + 35; c++) qhi.push_back(mk(c, 1'b1, 1'b0, 4'hF, "bypass_high"));
    RST_N = 1'b1;

    after_edge(L + 12);
    DIV     = 16'h3250;
    DIV_VLD = 1'b1;
    after_edge(L + 13);
    DIV_VLD = 1'b0;
    after_edge(L + 15);
    DIV     = 16'h3270;
    DIV_VLD = 1'b1;
    after_edge(L + 16);
    DIV_VLD = 1'b0;

    after_edge(L + 30);
    BYPASS = 1'b1;
    after_edge(L + 36);
    BYPASS = 1'b0;

    // Start a new update, then reset mid-cycle while it is pending.
    after_edge(L + 50);
    DIV     = 16'h3254;
    DIV_VLD = 1'b1;
    for (int c = L + 51; c <= L + 54; c++) qlo.push_back(mk(c, 1'b0, 1'b0, 4'h0, "reset_abort"));
    after_edge(L + 51);
    DIV_VLD = 1'b0;
    #2;
    RST_N = 1'b0;

    R2 = L + 54;
    L2 = R2 + LAT;
    after_edge(R2);
    for (int c = R2 + 1; c <= L2 + 16; c++) begin
      k = c - L2;
      qlo.push_back(mk(c, c >= L2, 1'b0,
                       {wave(k, 3), wave(k, 2), wave(k, 5), wave(k, 4)}, "relock"));
    end
    RST_N = 1'b1;

    after_edge(L2 + 17);
    #6;
    checks++;
    if (qlo.size() != 0 || qhi.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got lo=%0d hi=%0d pending expected 0", qlo.size(), qhi.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout at cyc=%0d expected completion", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
